// File: rtl/ad_ip_jesd204_tpl_pkg.sv
// Shared definitions for the JESD204 transport-layer ADC path.
// Covers PN select codes, PRBS tap masks, monitor thresholds and the PRBS step function.
package ad_ip_jesd204_tpl_pkg;

   typedef enum logic [1:0] {
      PN_OFF  = 2'd0,
      PN_PN7  = 2'd1,
      PN_PN15 = 2'd2,
      PN_RSVD = 2'd3
   } pn_sel_e;

   typedef enum logic {
      PN_OOS    = 1'b0,
      PN_INSYNC = 1'b1
   } pn_state_e;

   // Feedback taps on a 15-bit history register, bit 0 = most recent bit
   localparam logic [14:0] PN7_TAPS  = 15'h0060;
   localparam logic [14:0] PN15_TAPS = 15'h6000;

   localparam int unsigned OOS_THRESH = 4;
   localparam int unsigned ERR_THRESH = 8;

   // Next 16 PRBS bits, MSB first, continuing from the bit history held in x
   function automatic logic [15:0] pn_fn(input logic [15:0] x, input logic [14:0] taps);
      logic [14:0] s;
      logic [15:0] y;
      logic        b;
      s = x[14:0];
      y = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         b = ^(s & taps);
         s = {s[13:0], b};
         y = {y[14:0], b};
      end
      return y;
   endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_deframer_if.sv
// Link-side input and ADC-side output bundle of the transport-layer deframer.
interface ad_ip_jesd204_tpl_adc_deframer_if #(
   parameter int unsigned NUM_LANES       = 4,
   parameter int unsigned NUM_CHANNELS    = 2,
   parameter int unsigned OCTETS_PER_BEAT = 4,
   parameter int unsigned DATA_PATH_WIDTH = 4
);
   logic                                        link_valid;
   logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0]      link_data;
   logic                                        adc_valid;
   logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0]  adc_data;
   logic [NUM_CHANNELS-1:0]                     adc_pn_oos;
   logic [NUM_CHANNELS-1:0]                     adc_pn_err;

   modport master (
      output link_valid, link_data,
      input  adc_valid, adc_data, adc_pn_oos, adc_pn_err
   );

   modport slave (
      input  link_valid, link_data,
      output adc_valid, adc_data, adc_pn_oos, adc_pn_err
   );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
// Per-channel PN7/PN15 sequence monitor with lock/loss hysteresis.
module ad_ip_jesd204_tpl_adc_pnmon
   import ad_ip_jesd204_tpl_pkg::*;
#(
   parameter int unsigned DATA_PATH_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid,
   input  logic [DATA_PATH_WIDTH*16-1:0] data,
   input  logic [1:0]                   pn_sel,
   output logic                         pn_oos,
   output logic                         pn_err
);

   pn_state_e   state_q, state_d;
   pn_sel_e     sel_q, sel_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] last_q, last_d;
   logic        oos_q, oos_d;
   logic        err_q, err_d;
   logic [14:0] taps;
   logic        pn_on;
   logic        match;
   logic [15:0] prev;
   logic [15:0] cur;

   // Expected values always chain off received samples, so a bad sample only poisons its successor
   always_comb begin
      case (sel_q)
         PN_PN7:  taps = PN7_TAPS;
         PN_PN15: taps = PN15_TAPS;
         default: taps = '0;
      endcase
      pn_on = (sel_q == PN_PN7) || (sel_q == PN_PN15);
      match = 1'b1;
      prev  = last_q;
      cur   = '0;
      for (int unsigned s = 0; s < DATA_PATH_WIDTH; s++) begin
         cur = data[s*16 +: 16];
         if (cur != pn_fn(prev, taps)) match = 1'b0;
         prev = cur;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oos_d   = oos_q;
      err_d   = 1'b0;
      sel_d   = pn_sel_e'(pn_sel);
      last_d  = valid ? data[(DATA_PATH_WIDTH-1)*16 +: 16] : last_q;
      if ((pn_sel_e'(pn_sel) != sel_q) || !pn_on) begin
         state_d = PN_OOS;
         cnt_d   = '0;
         oos_d   = 1'b1;
      end else if (valid) begin
         if (state_q == PN_OOS) begin
            if (!match) begin
               cnt_d = '0;
            end else if (cnt_q == 4'(OOS_THRESH - 1)) begin
               state_d = PN_INSYNC;
               cnt_d   = '0;
               oos_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end else if (match) begin
            cnt_d = '0;
         end else begin
            err_d = 1'b1;
            if (cnt_q == 4'(ERR_THRESH - 1)) begin
               state_d = PN_OOS;
               cnt_d   = '0;
               oos_d   = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PN_OOS;
         sel_q   <= PN_OFF;
         cnt_q   <= '0;
         last_q  <= '0;
         oos_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         oos_q   <= oos_d;
         err_q   <= err_d;
      end
   end

   assign pn_oos = oos_q;
   assign pn_err = err_q;

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 RX transport layer: lane octets -> per-channel samples, format conversion, PN monitors.
module ad_ip_jesd204_tpl_adc_deframer
   import ad_ip_jesd204_tpl_pkg::*;
#(
   parameter int unsigned NUM_LANES            = 4,
   parameter int unsigned NUM_CHANNELS         = 2,
   parameter int unsigned BITS_PER_SAMPLE      = 16,
   parameter int unsigned CONVERTER_RESOLUTION = 16,
   parameter int unsigned OCTETS_PER_BEAT      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      adc_dfmt_enable,
   input  logic                      adc_dfmt_type,
   input  logic                      adc_dfmt_se,
   input  logic [NUM_CHANNELS*2-1:0] adc_pn_sel,
   ad_ip_jesd204_tpl_adc_deframer_if.slave bus
);

   localparam int unsigned DPW   = OCTETS_PER_BEAT*8*NUM_LANES/NUM_CHANNELS/BITS_PER_SAMPLE;
   localparam int unsigned WORDS = NUM_CHANNELS*DPW;
   localparam int unsigned DW    = WORDS*16;

   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_data_q, s1_data_d;
   logic          adc_valid_q, adc_valid_d;
   logic [DW-1:0] adc_data_q, adc_data_d;

   function automatic logic [15:0] dfmt_fn(input logic [15:0] d, input logic typ, input logic se);
      logic        msb;
      logic [15:0] y;
      msb = d[CONVERTER_RESOLUTION-1] ^ typ;
      y   = '0;
      for (int unsigned b = 0; b < 16; b++) begin
         if (b < CONVERTER_RESOLUTION - 1)       y[b] = d[b];
         else if (b == CONVERTER_RESOLUTION - 1) y[b] = msb;
         else                                    y[b] = se & msb;
      end
      return y;
   endfunction

   // Word j is octets 2j (high) and 2j+1 (low) of the flat lane bus; lanes are contiguous
   always_comb begin
      s1_valid_d = bus.link_valid;
      s1_data_d  = s1_data_q;
      if (bus.link_valid) begin
         for (int unsigned j = 0; j < WORDS; j++) begin
            s1_data_d[((j % NUM_CHANNELS)*DPW + j/NUM_CHANNELS)*16 +: 16] =
               {bus.link_data[j*16 +: 8], bus.link_data[j*16+8 +: 8]};
         end
      end
   end

   always_comb begin
      adc_valid_d = s1_valid_q;
      adc_data_d  = adc_data_q;
      if (s1_valid_q) begin
         for (int unsigned w = 0; w < WORDS; w++) begin
            adc_data_d[w*16 +: 16] = adc_dfmt_enable ?
               dfmt_fn(s1_data_q[w*16 +: 16], adc_dfmt_type, adc_dfmt_se) : s1_data_q[w*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         adc_valid_q <= 1'b0;
         adc_data_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         adc_valid_q <= adc_valid_d;
         adc_data_q  <= adc_data_d;
      end
   end

   assign bus.adc_valid = adc_valid_q;
   assign bus.adc_data  = adc_data_q;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pnmon
      ad_ip_jesd204_tpl_adc_pnmon #(
         .DATA_PATH_WIDTH (DPW)
      ) u_pnmon (
         .clk    (clk),
         .reset  (reset),
         .valid  (s1_valid_q),
         .data   (s1_data_q[c*DPW*16 +: DPW*16]),
         .pn_sel (adc_pn_sel[c*2 +: 2]),
         .pn_oos (bus.adc_pn_oos[c]),
         .pn_err (bus.adc_pn_err[c])
      );
   end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// Directed self-checking bench: reset, lane mapping, format conversion, PN7/PN15 lock and loss.
module tb_ad_ip_jesd204_tpl_adc_deframer;

   localparam int unsigned L   = 4;
   localparam int unsigned M   = 2;
   localparam int unsigned OPB = 4;
   localparam int unsigned DPW = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       adc_dfmt_enable;
   logic       adc_dfmt_type;
   logic       adc_dfmt_se;
   logic [3:0] adc_pn_sel;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   logic oos_seen_high = 1'b0;
   logic [14:0] hist;
   int pn_mode = 7;

   always #5 clk = ~clk;

   ad_ip_jesd204_tpl_adc_deframer_if #(
      .NUM_LANES       (L),
      .NUM_CHANNELS    (M),
      .OCTETS_PER_BEAT (OPB),
      .DATA_PATH_WIDTH (DPW)
   ) bus ();

   ad_ip_jesd204_tpl_adc_deframer #(
      .NUM_LANES            (L),
      .NUM_CHANNELS         (M),
      .BITS_PER_SAMPLE      (16),
      .CONVERTER_RESOLUTION (12),
      .OCTETS_PER_BEAT      (OPB)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .adc_dfmt_enable (adc_dfmt_enable),
      .adc_dfmt_type   (adc_dfmt_type),
      .adc_dfmt_se     (adc_dfmt_se),
      .adc_pn_sel      (adc_pn_sel),
      .bus             (bus)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      err_pulses += int'(bus.adc_pn_err[0]);
      oos_seen_high = oos_seen_high | bus.adc_pn_oos[0];
   endtask

   task automatic idle(input int n);
      bus.link_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Channel words (sample s at [s*16 +: 16]) to raw lane octets, octet 0 first
   function automatic logic [127:0] pack(input logic [63:0] ch0, input logic [63:0] ch1);
      logic [127:0] r;
      logic [15:0]  w0, w1;
      r = '0;
      for (int s = 0; s < 4; s++) begin
         w0 = ch0[s*16 +: 16];
         w1 = ch1[s*16 +: 16];
         r[s*32 +: 32] = {w1[7:0], w1[15:8], w0[7:0], w0[15:8]};
      end
      return r;
   endfunction

   task automatic gen_word(output logic [15:0] w);
      logic b;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         b = (pn_mode == 7) ? (hist[6] ^ hist[5]) : (hist[14] ^ hist[13]);
         hist = {hist[13:0], b};
         w = {w[14:0], b};
      end
   endtask

   task automatic pn_beat(input int cs);
      logic [63:0] c0;
      logic [15:0] w;
      for (int s = 0; s < 4; s++) begin
         gen_word(w);
         c0[s*16 +: 16] = w;
      end
      if (cs >= 0) c0[cs*16] = ~c0[cs*16];
      bus.link_valid = 1'b1;
      bus.link_data  = pack(c0, 64'h0);
      tick();
      bus.link_valid = 1'b0;
   endtask

   task automatic fmt_vec(input logic en, input logic typ, input logic se, input string tag,
                          input logic [127:0] exp);
      adc_dfmt_enable = en;
      adc_dfmt_type   = typ;
      adc_dfmt_se     = se;
      bus.link_valid  = 1'b1;
      bus.link_data   = pack(64'h0FFF_0000_07FF_0800, 64'h1800_8000_0ABC_F123);
      tick();
      idle(1);
      check(tag, bus.adc_data, exp);
   endtask

   localparam logic [127:0] MAP_IN  = 128'h00FFEEDD_CCBBAA99_88776655_44332211;
   localparam logic [127:0] MAP_EXP = 128'hFF00_BBCC_7788_3344_DDEE_99AA_5566_1122;

   initial begin
      reset = 1'b1;
      adc_dfmt_enable = 1'b0;
      adc_dfmt_type = 1'b0;
      adc_dfmt_se = 1'b0;
      adc_pn_sel = 4'b0000;
      bus.link_valid = 1'b0;
      bus.link_data = '0;
      tick();
      tick();
      check("rst_valid", 128'(bus.adc_valid), 128'd0);
      check("rst_data", bus.adc_data, 128'd0);
      check("rst_oos", 128'(bus.adc_pn_oos), 128'd3);
      check("rst_err", 128'(bus.adc_pn_err), 128'd0);
      reset = 1'b0;
      idle(1);

      // Lane mapping and two-clock latency
      bus.link_valid = 1'b1;
      bus.link_data = MAP_IN;
      tick();
      bus.link_valid = 1'b0;
      check("map_lat1_valid", 128'(bus.adc_valid), 128'd0);
      tick();
      check("map_lat2_valid", 128'(bus.adc_valid), 128'd1);
      check("map_data", bus.adc_data, MAP_EXP);
      tick();
      check("map_valid_drop", 128'(bus.adc_valid), 128'd0);
      check("map_hold", bus.adc_data, MAP_EXP);

      // Reset during a valid stream
      bus.link_valid = 1'b1;
      tick();
      tick();
      check("mid_pre_valid", 128'(bus.adc_valid), 128'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", 128'(bus.adc_valid), 128'd0);
      check("mid_rst_data", bus.adc_data, 128'd0);
      check("mid_rst_oos", 128'(bus.adc_pn_oos), 128'd3);
      check("mid_rst_err", 128'(bus.adc_pn_err), 128'd0);
      reset = 1'b0;
      idle(2);

      // Format conversion, N=12
      fmt_vec(1'b1, 1'b1, 1'b1, "fmt_t1_se1", 128'h0000_F800_02BC_F923_07FF_F800_FFFF_0000);
      fmt_vec(1'b1, 1'b0, 1'b1, "fmt_t0_se1", 128'hF800_0000_FABC_0123_FFFF_0000_07FF_F800);
      fmt_vec(1'b1, 1'b1, 1'b0, "fmt_t1_se0", 128'h0000_0800_02BC_0923_07FF_0800_0FFF_0000);
      fmt_vec(1'b0, 1'b1, 1'b1, "fmt_off", 128'h1800_8000_0ABC_F123_0FFF_0000_07FF_0800);
      adc_dfmt_enable = 1'b0;

      // PN7 lock: first beat reseeds from a zeroed history, next four match
      reset = 1'b1;
      tick();
      reset = 1'b0;
      adc_pn_sel = 4'b0001;
      idle(2);
      pn_mode = 7;
      hist = 15'h0001;
      repeat (4) pn_beat(-1);
      idle(2);
      check("pn7_oos_3match", 128'(bus.adc_pn_oos), 128'd3);
      pn_beat(-1);
      check("pn7_lock_lat1", 128'(bus.adc_pn_oos), 128'd3);
      idle(1);
      check("pn7_lock", 128'(bus.adc_pn_oos), 128'd2);
      err_pulses = 0;
      repeat (1000) pn_beat(-1);
      idle(2);
      check("pn7_1000_err", 128'(err_pulses), 128'd0);
      check("pn7_1000_oos", 128'(bus.adc_pn_oos), 128'd2);

      // Single corrupted last sample: two mismatching beats, lock kept
      err_pulses = 0;
      oos_seen_high = 1'b0;
      pn_beat(3);
      repeat (3) pn_beat(-1);
      idle(2);
      check("inj_err_pulses", 128'(err_pulses), 128'd2);
      check("inj_oos_stayed", 128'(oos_seen_high), 128'd0);

      // Eight consecutive bad beats drop lock, seven do not
      err_pulses = 0;
      repeat (7) pn_beat(1);
      idle(2);
      check("bad7_oos", 128'(bus.adc_pn_oos), 128'd2);
      pn_beat(1);
      idle(2);
      check("bad8_oos", 128'(bus.adc_pn_oos), 128'd3);
      check("bad8_err_pulses", 128'(err_pulses), 128'd8);

      // Relock, then ride through random gaps
      repeat (6) pn_beat(-1);
      idle(2);
      check("relock_pn7", 128'(bus.adc_pn_oos), 128'd2);
      err_pulses = 0;
      oos_seen_high = 1'b0;
      repeat (200) begin
         pn_beat(-1);
         idle(int'($urandom_range(0, 3)));
      end
      idle(2);
      check("gaps_err", 128'(err_pulses), 128'd0);
      check("gaps_oos_stayed", 128'(oos_seen_high), 128'd0);

      // Select change forces OOS on the next clock, then PN15 lock
      adc_pn_sel = 4'b0010;
      tick();
      check("sel_change_oos", 128'(bus.adc_pn_oos), 128'd3);
      pn_mode = 15;
      hist = 15'h0001;
      repeat (6) pn_beat(-1);
      idle(2);
      check("pn15_lock", 128'(bus.adc_pn_oos), 128'd2);
      adc_pn_sel = 4'b0000;
      tick();
      check("sel_off_oos", 128'(bus.adc_pn_oos), 128'd3);
      check("sel_off_err", 128'(bus.adc_pn_err), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_deframer.md
Name: ad_ip_jesd204_tpl_adc_deframer

Overview:
Receive-side JESD204 transport-layer deframer. It takes octet-parallel lane data from the link layer and rebuilds per-channel converter samples. It then applies the selected data-format conversion and runs a per-channel PN sequence monitor for link/converter test. It sits between the JESD204 RX link layer and the ADC channel/DMA path, running on the link clock.

Parameters:
NUM_LANES, 4, number of JESD lanes (L)
NUM_CHANNELS, 2, number of converters (M)
BITS_PER_SAMPLE, 16, sample container width (N'); only 16 supported
CONVERTER_RESOLUTION, 16, converter bits (N), 8..16
OCTETS_PER_BEAT, 4, octets per lane per clk
DATA_PATH_WIDTH, derived, OCTETS_PER_BEAT*8*NUM_LANES/NUM_CHANNELS/BITS_PER_SAMPLE, samples per channel per beat

Ports:
clk  in  1  link clock (line-rate/40)
reset  in  1  synchronous, active-high
link_valid  in  1  link_data qualifier
link_data  in  NUM_LANES*OCTETS_PER_BEAT*8  lane l at [l*OPB*8 +: OPB*8]; octet 0 (LSB) received first
adc_dfmt_enable  in  1  enable format conversion
adc_dfmt_type  in  1  1 = offset binary (invert MSB at bit N-1)
adc_dfmt_se  in  1  1 = sign-extend bit N-1 to 16 bits
adc_pn_sel  in  NUM_CHANNELS*2  per channel: 0 off, 1 PN7 (x^7+x^6+1), 2 PN15 (x^15+x^14+1), 3 reserved = off
adc_valid  out  1  adc_data qualifier
adc_data  out  NUM_CHANNELS*DATA_PATH_WIDTH*16  channel c sample s at [(c*DPW+s)*16 +: 16]; s=0 oldest
adc_pn_oos  out  NUM_CHANNELS  PN monitor out-of-sync
adc_pn_err  out  NUM_CHANNELS  one-cycle pulse on PN mismatch while in sync

Behaviour:
- Reset values: adc_valid=0, adc_data=0, adc_pn_oos=all 1, adc_pn_err=0; all pipeline and LFSR state cleared. Reset has priority over every other event.
- Deframe (stage 1, registered):
  - Per lane, byte-swap octets so octet 0 is the MSB.
  - Concatenate lanes in order 0..L-1 and split into 16-bit words j = 0..(L*OPB/2 - 1).
  - Word j maps to channel (j mod M), sample (j div M).
  - Field extraction is pure wiring; one register stage.
- Format (stage 2, registered):
  - dfmt_enable=0: pass through unchanged.
  - Otherwise, with d[N-1:0] as the sample: bit N-1 is inverted if type=1; bits [15:N] take the resulting bit N-1 if se=1, else 0.
  - Latency link_valid -> adc_valid is exactly 2 clk. Valid pipeline is unconditional; no backpressure.
  - On beats with link_valid=0, data registers hold their previous value and adc_valid=0.
- PN monitor (per channel, on stage-1 samples, runs only on valid beats):
  - pn_fn(x) = next 16 bits of the selected PRBS, serially generated MSB-first with state seeded from x.
  - Expected sample s = pn_fn(sample s-1); sample -1 = last sample of the previous valid beat.
  - State OOS: each valid beat reseeds from the received data. Beat matches if all DPW samples equal the expected values. 4 consecutive matching beats -> INSYNC (adc_pn_oos=0).
  - State INSYNC: any mismatch -> adc_pn_err=1 for one cycle and mismatch counter +1; a matching beat clears the counter; 8 consecutive mismatching beats -> OOS.
  - The expected sequence keeps free-running from received data, so a single corrupted sample costs at most 2 mismatching beats.
  - Changing adc_pn_sel (including to off) forces OOS and clears counters on the next clk. Off: adc_pn_oos=1, adc_pn_err=0.
  - Counters saturate (4-bit) and never wrap.
  - Monitor outputs are registered and aligned with adc_valid (2-clk latency).

Decomposition:
- Shared package ad_ip_jesd204_tpl_pkg: PN select encodings, PN7/PN15 polynomial constants, OOS_THRESH=4, ERR_THRESH=8.
- Sub-module ad_ip_jesd204_tpl_adc_pnmon: one channel, DPW samples, state machine plus counters; instantiated NUM_CHANNELS times.

Test Plan:
1. Reset mid-stream: assert reset for 1 clk during valid data -> next clk adc_valid=0, adc_data=0, adc_pn_oos=2'b11, no err pulse.
2. Mapping, L=4 M=2 OPB=4: lane0 = 0x44332211 (octet0=0x11) -> ch0 s0 = 0x1122, ch1 s0 = 0x3344; adc_valid high exactly 2 clk after link_valid.
3. Format, N=12, enable=1, type=1, se=1: input 0x0800 -> 0x0000; input 0x07FF -> 0xFFFF; input 0x0000 -> 0xF800.
4. PN7 lock: ideal PN7 stream on ch0 with sel=1 -> adc_pn_oos[0] falls after the 4th matching beat (+2 clk latency); err stays 0 for 1000 beats.
5. Error injection: flip one bit in one sample while INSYNC -> 1 or 2 single-cycle err pulses, oos stays 0; 8 consecutive corrupted beats -> oos=1.
6. Gaps and select change: random link_valid=0 gaps -> lock kept; switch sel 1->2 -> oos=1 next clk, relocks on PN15 data.
